// File: rtl/bru_exe.sv
// bru_exe: branch resolve stage, consumer end of the BRU issue handshake.
// Ports: CLK/RST, issue word in (vaild/ready), flush, result queue head out, pop, count.
module bru_exe #(
  parameter int EXE_DW = 134,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bru_exeparam_vaild,
  input  logic [EXE_DW-1:0] bru_exeparam,
  output logic              bru_exeparam_ready,
  input  logic              flush,
  output logic              bru_res_vaild,
  output logic              bru_res_taken,
  output logic              bru_res_illegal,
  input  logic              bru_res_pop,
  output logic [AW:0]       bru_res_cnt
);

  typedef struct packed {
    logic taken;
    logic illegal;
  } res_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  res_t          ent [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;

  logic [5:0]  op;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        eq;
  logic        lt_s;
  logic        lt_u;
  logic [5:0]  hit;
  logic        legal;
  res_t        new_ent;

  logic        accept;
  logic        pop_eff;
  logic [AW:0] acc_w;
  logic [AW:0] pop_w;

  assign op  = bru_exeparam[133:128];
  assign op1 = bru_exeparam[127:64];
  assign op2 = bru_exeparam[63:0];

  assign eq   = (op1 == op2);
  assign lt_s = ($signed(op1) < $signed(op2));
  assign lt_u = (op1 < op2);

  // Condition per op bit, same order as the select field:
  // beq, bne, blt, bge, bltu, bgeu.
  assign hit = {eq, ~eq, lt_s, ~lt_s, lt_u, ~lt_u};

  // Exactly one select bit: nonzero and clearing the lowest set bit leaves zero.
  assign legal = (|op) && ~|(op & (op - 6'd1));

  always_comb begin
    new_ent         = '0;
    new_ent.illegal = ~legal;
    new_ent.taken   = legal & |(op & hit);
  end

  assign bru_exeparam_ready = (cnt != FULL);
  assign bru_res_vaild      = (cnt != '0);

  assign accept  = bru_exeparam_vaild & bru_exeparam_ready & ~flush;
  assign pop_eff = bru_res_pop & bru_res_vaild & ~flush;

  assign acc_w = {{AW{1'b0}}, accept};
  assign pop_w = {{AW{1'b0}}, pop_eff};

  always_comb begin
    bru_res_taken   = 1'b0;
    bru_res_illegal = 1'b0;
    if (bru_res_vaild) begin
      bru_res_taken   = ent[rptr].taken;
      bru_res_illegal = ent[rptr].illegal;
    end
  end

  assign bru_res_cnt = cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (accept) begin
        ent[wptr] <= new_ent;
        wptr      <= wptr + 1'b1;
      end
      if (pop_eff) begin
        rptr <= rptr + 1'b1;
      end
      cnt <= cnt + acc_w - pop_w;
    end
  end

endmodule

// File: tb/tb_bru_exe.sv
// tb_bru_exe: directed and random stimulus for bru_exe,
// checked every cycle against a queue-based reference.
module tb_bru_exe;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  localparam logic [5:0] BEQ  = 6'b100000;
  localparam logic [5:0] BNE  = 6'b010000;
  localparam logic [5:0] BLT  = 6'b001000;
  localparam logic [5:0] BGE  = 6'b000100;
  localparam logic [5:0] BLTU = 6'b000010;
  localparam logic [5:0] BGEU = 6'b000001;

  logic         CLK = 0;
  logic         RST = 1;
  logic         bru_exeparam_vaild = 0;
  logic [133:0] bru_exeparam = '0;
  logic         bru_exeparam_ready;
  logic         flush = 0;
  logic         bru_res_vaild;
  logic         bru_res_taken;
  logic         bru_res_illegal;
  logic         bru_res_pop = 0;
  logic [AW:0]  bru_res_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Each queued result: bit1 = illegal, bit0 = taken.
  logic [1:0] mq[$];

  bru_exe #(.EXE_DW(134), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .bru_exeparam_vaild (bru_exeparam_vaild),
    .bru_exeparam       (bru_exeparam),
    .bru_exeparam_ready (bru_exeparam_ready),
    .flush              (flush),
    .bru_res_vaild      (bru_res_vaild),
    .bru_res_taken      (bru_res_taken),
    .bru_res_illegal    (bru_res_illegal),
    .bru_res_pop        (bru_res_pop),
    .bru_res_cnt        (bru_res_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [1:0] ref_res(logic [5:0] op,
                                         logic [63:0] a,
                                         logic [63:0] b);
    longint sa;
    longint sb;
    sa = a;
    sb = b;
    if ($countones(op) != 1) return 2'b10;
    case (op)
      BEQ:     return {1'b0, a == b};
      BNE:     return {1'b0, a != b};
      BLT:     return {1'b0, sa < sb};
      BGE:     return {1'b0, sa >= sb};
      BLTU:    return {1'b0, a < b};
      default: return {1'b0, a >= b};
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [1:0] h;
    h = (mq.size() != 0) ? mq[0] : 2'b00;
    chk({tag, ".ready"},   bru_exeparam_ready, mq.size() != DEPTH);
    chk({tag, ".vaild"},   bru_res_vaild,      mq.size() != 0);
    chk({tag, ".taken"},   bru_res_taken,      h[0]);
    chk({tag, ".illegal"}, bru_res_illegal,    h[1]);
    chk({tag, ".cnt"},     bru_res_cnt,        mq.size());
  endtask

  // One clock: predict from the inputs currently driven, advance, compare.
  task automatic tick(string tag);
    bit         acc;
    bit         pp;
    logic [1:0] e;
    acc = bru_exeparam_vaild && (mq.size() != DEPTH) && !flush;
    pp  = bru_res_pop && (mq.size() != 0) && !flush;
    e   = ref_res(bru_exeparam[133:128], bru_exeparam[127:64],
                  bru_exeparam[63:0]);
    @(posedge CLK);
    if (RST || flush) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(logic v, logic [5:0] op,
                       logic [63:0] a, logic [63:0] b);
    bru_exeparam_vaild = v;
    bru_exeparam = {op, a, b};
  endtask

  task automatic issue(string tag, logic [5:0] op,
                       logic [63:0] a, logic [63:0] b);
    drive(1'b1, op, a, b);
    tick(tag);
    bru_exeparam_vaild = 0;
  endtask

  task automatic drain(string tag);
    bru_res_pop = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick(tag);
    bru_res_pop = 0;
  endtask

  initial begin
    logic [5:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;

    // Reset state
    #1;
    check_all("rst_async");
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    check_all("rst_rel");
    tick("idle");

    // beq equal operands, then pop
    issue("beq_eq", BEQ, 64'h5, 64'h5);
    chk("beq_taken", bru_res_taken, 1'b1);
    bru_res_pop = 1;
    tick("beq_pop");
    bru_res_pop = 0;
    chk("beq_empty", bru_res_vaild, 1'b0);

    // Signedness
    issue("blt",  BLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    issue("bltu", BLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    issue("bge",  BGE,  64'h8000_0000_0000_0000, 64'h0);
    issue("bgeu", BGEU, 64'h8000_0000_0000_0000, 64'h0);
    chk("sign_cnt", bru_res_cnt, 3'd4);
    drain("sign_drain");

    // Fill, hold a fifth word, then one pop lets it in
    issue("fill0", BEQ, 64'h1, 64'h1);
    issue("fill1", BNE, 64'h1, 64'h1);
    issue("fill2", BNE, 64'h1, 64'h2);
    issue("fill3", BEQ, 64'h1, 64'h2);
    chk("full_ready", bru_exeparam_ready, 1'b0);
    drive(1'b1, BEQ, 64'h7, 64'h7);
    repeat (3) tick("held");
    bru_res_pop = 1;
    tick("full_pop");
    bru_res_pop = 0;
    chk("full_reopen", bru_exeparam_ready, 1'b1);
    tick("fifth_acc");
    bru_exeparam_vaild = 0;
    drain("fill_drain");

    // Stream 10 alternating results, popping every cycle after the first
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, BEQ, 64'(i), (i % 2 == 0) ? 64'(i) : 64'(i + 1));
      bru_res_pop = (i != 0);
      tick("stream");
      if (i != 0) chk("stream_cnt", bru_res_cnt, 3'd1);
    end
    bru_exeparam_vaild = 0;
    drain("stream_drain");

    // Illegal selects and pop while empty
    issue("ill_zero", 6'b000000, 64'h3, 64'h3);
    issue("ill_two",  6'b110000, 64'h3, 64'h3);
    drain("ill_drain");
    bru_res_pop = 1;
    repeat (2) tick("pop_empty");
    bru_res_pop = 0;

    // Flush with cnt = 3 plus concurrent valid and pop
    issue("pf0", BNE, 64'h1, 64'h2);
    issue("pf1", BNE, 64'h1, 64'h2);
    issue("pf2", BNE, 64'h1, 64'h2);
    drive(1'b1, BEQ, 64'h9, 64'h9);
    bru_res_pop = 1;
    flush = 1;
    tick("flush");
    flush = 0;
    bru_res_pop = 0;
    bru_exeparam_vaild = 0;
    chk("flush_cnt", bru_res_cnt, 3'd0);
    tick("post_flush");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       rop = 6'($urandom);
        default: rop = 6'b1 << $urandom_range(0, 5);
      endcase
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = {$urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0,
                       $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      drive($urandom_range(0, 3) != 0, rop, ra, rb);
      bru_res_pop = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      tick("rand");
    end
    flush = 0;
    bru_exeparam_vaild = 0;
    drain("rand_drain");

    // Reset mid-stream
    issue("pr0", BEQ, 64'h4, 64'h4);
    issue("pr1", BEQ, 64'h4, 64'h4);
    RST = 1;
    #1;
    mq.delete();
    check_all("rst_mid");
    tick("rst_hold");
    RST = 0;
    tick("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bru_exe.md
Name: bru_exe

Overview:
- Consumer end of the BRU issue-to-execute handshake.
- Accepts issued branch parameter words (op select plus two 64-bit operands) on a valid/ready handshake.
- Evaluates the branch condition and buffers each resolution in an in-order result queue, which the commit/redirect logic drains with a pop strobe.
- Backpressure on the issue side comes only from queue occupancy.

Parameters:
EXE_DW, 134, width of the issued parameter word (6 op bits + 64 + 64)
DEPTH, 4, result queue entries; must be a power of two, ≥2
AW, 2, pointer width, log2(DEPTH)

Ports:
CLK  input  1  clock (one clock domain)
RST  input  1  reset, asynchronous, active-high
bru_exeparam_vaild  input  1  issued word valid
bru_exeparam  input  EXE_DW  issued word: [133]beq [132]bne [131]blt [130]bge [129]bltu [128]bgeu [127:64]op1 [63:0]op2
bru_exeparam_ready  output  1  block can accept a word this cycle
flush  input  1  synchronous pipeline flush
bru_res_vaild  output  1  queue head valid
bru_res_taken  output  1  head entry branch taken
bru_res_illegal  output  1  head entry op select not one-hot
bru_res_pop  input  1  consumer takes head entry
bru_res_cnt  output  AW+1  current occupancy

Behaviour:
- Reset (async assert, sync release): wptr = rptr = 0, cnt = 0, all entries cleared.
  - Resulting outputs: ready = 1, res_vaild = 0, res_taken = 0, res_illegal = 0, res_cnt = 0.
- ready = (cnt != DEPTH). Depends on registered state only; no combinational path from bru_res_pop or bru_exeparam_vaild.
- accept = vaild & ready & ~flush. The upstream holds its word until it sees ready; an unaccepted word is never consumed.
- Compare (combinational in the accept cycle):
  - beq: op1 == op2
  - bne: op1 != op2
  - blt: $signed(op1) < $signed(op2)
  - bge: signed op1 ≥ op2
  - bltu: unsigned op1 < op2
  - bgeu: unsigned op1 ≥ op2
- Op select not exactly one-hot (zero or more than one bit set): entry written with taken = 0, illegal = 1. Otherwise illegal = 0.
- Latency: a word accepted in cycle N is written at the end of N and appears at the head in cycle N+1 if the queue was empty. No bypass from input to output.
- Head outputs: res_vaild = (cnt != 0). taken/illegal are read from entry[rptr] when valid and forced to 0 when empty.
- pop_eff = bru_res_pop & res_vaild & ~flush. A pop while empty is ignored and has no pointer effect.
- Pointer and count update:
  - accept: wptr += 1
  - pop_eff: rptr += 1
  - Both pointers wrap modulo DEPTH naturally via AW bits.
  - cnt += accept − pop_eff; a simultaneous accept and pop leaves cnt unchanged.
- Full: ready = 0, so no push. A pop while full frees an entry; ready rises the next cycle.
- flush: at the next edge wptr = rptr = 0 and cnt = 0; same-cycle accept and pop are discarded. Entry contents need not be cleared.
- Reset mid-operation: all queued results are lost, and outputs go to reset values immediately on assert.
- Result order is strictly FIFO in accept order.

Test Plan:
- beq, op1 = op2 = 0x5 accepted in cycle 3 → cycle 4: res_vaild = 1, taken = 1, illegal = 0, cnt = 1; pop → cycle 5: res_vaild = 0, cnt = 0.
- Signedness: blt op1 = 0xFFFF_FFFF_FFFF_FFFF, op2 = 1 → taken = 1. bltu same operands → taken = 0. bge op1 = 0x8000_0000_0000_0000, op2 = 0 → taken = 0. bgeu same → taken = 1.
- Fill: 4 valid words with no pop → after 4 accepts cnt = 4 and ready = 0. A 5th word held valid for 3 cycles is not accepted. One pop → ready = 1 next cycle, 5th word accepted, and head order is preserved.
- Wrap and concurrency:
  - Stream 10 words with alternating taken results while popping every cycle after the first.
  - Push and pop coincide each cycle: cnt stays 1.
  - Popped sequence matches issue order across pointer wrap.
- Edge cases:
  - op select 6'b000000 → illegal = 1, taken = 0.
  - op select 6'b110000 → illegal = 1, taken = 0.
  - Pop while empty → no change.
- Flush and reset:
  - With cnt = 3, flush asserted together with vaild and pop → next cycle cnt = 0, res_vaild = 0, and the flushed-cycle word is not queued.
  - RST asserted mid-stream → outputs go to reset values in the same cycle.
